// File: rtl/rr_stream_arbiter_if.sv
// Stream bundle for rr_stream_arbiter: N_CH input channels merged onto one output stream.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface rr_stream_arbiter_if #(
  parameter int unsigned BIT_DEPTH = 8,
  parameter int unsigned N_CH      = 4
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [BIT_DEPTH-1:0] t_data_i [N_CH-1:0];
  logic [N_CH-1:0]      t_valid_i;
  logic [N_CH-1:0]      t_last_i;
  logic [N_CH-1:0]      t_ready_o;
  logic [BIT_DEPTH-1:0] t_data_o;
  logic                 t_valid_o;
  logic                 t_last_o;
  logic [CH_W-1:0]      t_id_o;
  logic                 t_ready_i;

  modport slave (
    input  t_data_i, t_valid_i, t_last_i, t_ready_i,
    output t_ready_o, t_data_o, t_valid_o, t_last_o, t_id_o
  );

  modport master (
    output t_data_i, t_valid_i, t_last_i, t_ready_i,
    input  t_ready_o, t_data_o, t_valid_o, t_last_o, t_id_o
  );
endinterface

// File: rtl/rr_stream_arbiter.sv
// N-channel round-robin stream arbiter with per-packet grant lock and a one-entry
// registered output stage.
module rr_stream_arbiter #(
  parameter int unsigned BIT_DEPTH = 8,
  parameter int unsigned N_CH      = 4,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input logic             clk,
  input logic             arstn,
  rr_stream_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e               state_q, state_d;
  logic [CH_W-1:0]      ptr_q, ptr_d;
  logic [CH_W-1:0]      lock_q, lock_d;
  logic [BIT_DEPTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [CH_W-1:0]      id_q, id_d;

  logic                 gnt_any;
  logic [CH_W-1:0]      gnt_id;
  logic [CH_W-1:0]      idx;
  logic                 can_load;
  logic                 accept;

  assign can_load = !valid_q || bus.t_ready_i;

  // Locked grant ignores other valids; idle grant searches ptr, ptr+1, ... mod N_CH.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    if (state_q == StLocked) begin
      gnt_any = 1'b1;
      gnt_id  = lock_q;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        idx = CH_W'((32'(ptr_q) + k) % N_CH);
        if (!gnt_any && bus.t_valid_i[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = idx;
        end
      end
    end
  end

  assign accept = gnt_any && can_load && bus.t_valid_i[gnt_id];

  // Ready is gated by the reset input so nothing looks acceptable while held in reset.
  always_comb begin
    bus.t_ready_o = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      bus.t_ready_o[i] = arstn && gnt_any && can_load && (gnt_id == CH_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    id_d    = id_q;
    if (accept) begin
      data_d  = bus.t_data_i[gnt_id];
      last_d  = bus.t_last_i[gnt_id];
      id_d    = gnt_id;
      valid_d = 1'b1;
      if (bus.t_last_i[gnt_id]) begin
        state_d = StIdle;
        ptr_d   = (gnt_id == CH_W'(N_CH - 1)) ? '0 : gnt_id + CH_W'(1);
      end else begin
        state_d = StLocked;
        lock_d  = gnt_id;
      end
    end else if (can_load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      lock_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      id_q    <= id_d;
    end
  end

  assign bus.t_data_o  = data_q;
  assign bus.t_valid_o = valid_q;
  assign bus.t_last_o  = last_q;
  assign bus.t_id_o    = id_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: per-channel packet queues feed the DUT, and a cycle model
// built from the arbitration rules predicts ready and output every cycle.
module tb_rr_stream_arbiter;
  localparam int unsigned BIT_DEPTH = 8;
  localparam int unsigned N_CH      = 4;

  logic clk;
  logic arstn;

  int checks;
  int errors;

  // Reference model: lock < 0 means no packet in progress.
  int         m_ptr;
  int         m_lock;
  int         m_oid;
  int         acc_ch;
  logic       m_ov;
  logic       m_ol;
  logic [7:0] m_od;

  // Per-channel pending beats, {last, data}.
  logic [8:0] src_q [N_CH][$];

  rr_stream_arbiter_if #(.BIT_DEPTH(BIT_DEPTH), .N_CH(N_CH)) bus ();

  rr_stream_arbiter #(.BIT_DEPTH(BIT_DEPTH), .N_CH(N_CH)) dut (
    .clk  (clk),
    .arstn(arstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_lock = -1;
    m_ov   = 1'b0;
    m_ol   = 1'b0;
    m_od   = 8'h00;
    m_oid  = 0;
  endtask

  task automatic drive(input bit gate, input bit rdy);
    for (int c = 0; c < int'(N_CH); c++) begin
      if (src_q[c].size() != 0 && (!gate || $urandom_range(3) != 0)) begin
        bus.t_valid_i[c] = 1'b1;
        bus.t_data_i[c]  = src_q[c][0][7:0];
        bus.t_last_i[c]  = src_q[c][0][8];
      end else begin
        bus.t_valid_i[c] = 1'b0;
        bus.t_data_i[c]  = 8'($urandom);
        bus.t_last_i[c]  = 1'($urandom);
      end
    end
    bus.t_ready_i = rdy;
  endtask

  // Check ready and outputs against the model, advance the model, then pass the edge.
  task automatic step();
    int                g;
    logic              can;
    logic [N_CH-1:0]   er;
    #1;
    can = !m_ov || bus.t_ready_i;
    g   = -1;
    if (m_lock >= 0) begin
      g = m_lock;
    end else begin
      for (int k = 0; k < int'(N_CH); k++) begin
        int c;
        c = (m_ptr + k) % int'(N_CH);
        if (g < 0 && bus.t_valid_i[c]) g = c;
      end
    end
    er = '0;
    if (g >= 0 && can) er[g] = 1'b1;
    check_val("ready_o", 32'(bus.t_ready_o), 32'(er));
    check_val("valid_o", 32'(bus.t_valid_o), 32'(m_ov));
    check_val("data_o",  32'(bus.t_data_o),  32'(m_od));
    check_val("last_o",  32'(bus.t_last_o),  32'(m_ol));
    check_val("id_o",    32'(bus.t_id_o),    32'(m_oid));
    acc_ch = -1;
    if (g >= 0 && can && bus.t_valid_i[g]) begin
      acc_ch = g;
      m_ov   = 1'b1;
      m_od   = bus.t_data_i[g];
      m_ol   = bus.t_last_i[g];
      m_oid  = g;
      if (bus.t_last_i[g]) begin
        m_lock = -1;
        m_ptr  = (g + 1) % int'(N_CH);
      end else begin
        m_lock = g;
      end
    end else if (can) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    if (acc_ch >= 0) void'(src_q[acc_ch].pop_front());
  endtask

  task automatic cycle(input bit gate, input bit rdy);
    @(negedge clk);
    drive(gate, rdy);
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    arstn  = 1'b0;
    for (int c = 0; c < int'(N_CH); c++) begin
      bus.t_valid_i[c] = 1'b1;
      bus.t_data_i[c]  = 8'(8'h10 + c);
      bus.t_last_i[c]  = 1'b1;
    end
    bus.t_ready_i = 1'b1;
    model_reset();

    // Reset with every channel valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_val("rst_ready", 32'(bus.t_ready_o), 32'h0);
    check_val("rst_valid", 32'(bus.t_valid_o), 32'h0);
    check_val("rst_data",  32'(bus.t_data_o),  32'h0);
    check_val("rst_last",  32'(bus.t_last_o),  32'h0);
    check_val("rst_id",    32'(bus.t_id_o),    32'h0);
    bus.t_valid_i = '0;
    arstn = 1'b1;

    // Fairness: four always-valid channels of single-beat packets.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < int'(N_CH); c++) src_q[c].push_back({1'b1, 8'(8'h10 + c)});
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      if (n > 0) begin
        check_val("fair_id",   32'(bus.t_id_o),   32'((n - 1) % 4));
        check_val("fair_data", 32'(bus.t_data_o), 32'(8'h10 + (n - 1) % 4));
      end
      drive(1'b0, 1'b1);
      step();
    end

    // Packet lock: ch1 three-beat packet must not be split by ch2.
    src_q[1].push_back({1'b0, 8'hA0});
    src_q[1].push_back({1'b0, 8'hA1});
    src_q[1].push_back({1'b1, 8'hA2});
    src_q[2].push_back({1'b1, 8'hB0});
    repeat (6) cycle(1'b0, 1'b1);

    // Backpressure holding 0x11.
    src_q[1].push_back({1'b1, 8'h11});
    src_q[1].push_back({1'b1, 8'h12});
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    #1;
    check_val("bp_hold", 32'(bus.t_data_o), 32'h11);
    repeat (4) cycle(1'b0, 1'b1);

    // Wrap: lone ch3 moves the pointer to 0, so ch0 beats ch3 next.
    src_q[3].push_back({1'b1, 8'h33});
    repeat (2) cycle(1'b0, 1'b1);
    src_q[0].push_back({1'b1, 8'h00});
    src_q[3].push_back({1'b1, 8'h34});
    cycle(1'b0, 1'b1);
    #1;
    check_val("wrap_id", 32'(bus.t_id_o), 32'h0);
    repeat (3) cycle(1'b0, 1'b1);

    // Reset in the middle of a ch1 packet.
    src_q[1].push_back({1'b0, 8'hC0});
    src_q[1].push_back({1'b0, 8'hC1});
    src_q[1].push_back({1'b1, 8'hC2});
    repeat (2) cycle(1'b0, 1'b1);
    #1 arstn = 1'b0;
    #1;
    check_val("midrst_valid", 32'(bus.t_valid_o), 32'h0);
    check_val("midrst_ready", 32'(bus.t_ready_o), 32'h0);
    model_reset();
    src_q[1].delete();
    #2 arstn = 1'b1;
    src_q[0].push_back({1'b1, 8'hD0});
    src_q[1].push_back({1'b1, 8'hD1});
    cycle(1'b0, 1'b1);
    #1;
    check_val("midrst_first", 32'(bus.t_id_o), 32'h0);
    repeat (3) cycle(1'b0, 1'b1);

    // Random packets, random valid gaps and random backpressure.
    repeat (800) begin
      for (int c = 0; c < int'(N_CH); c++) begin
        if (src_q[c].size() < 3 && $urandom_range(3) == 0) begin
          int len;
          len = int'($urandom_range(4, 1));
          for (int b = 0; b < len; b++) src_q[c].push_back({1'(b == len - 1), 8'($urandom)});
        end
      end
      cycle(1'b1, $urandom_range(3) != 0);
    end
    repeat (40) cycle(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- Parametrised N-channel round-robin stream arbiter; successor to the fixed 2-input arbiter.
- Merges N_CH valid/ready input streams onto one registered output stream.
- Grants are fair round-robin and locked per packet (t_last), so beats of different packets never interleave.
- Sits in front of shared consumers (bus/memory port, debug UART) that accept one stream.

Parameters:
- BIT_DEPTH, 8, data width of every channel and of the output.
- N_CH, 4, number of input channels; legal range 1..16.
- CH_W, max(1,$clog2(N_CH)), derived width of the channel index; not overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- arstn  in  1  asynchronous active-low reset.
- t_data_i  in  N_CH x BIT_DEPTH  per-channel data; unpacked array indexed [N_CH-1:0].
- t_valid_i  in  N_CH  per-channel valid.
- t_last_i  in  N_CH  per-channel end-of-packet marker.
- t_ready_o  out  N_CH  per-channel ready; at most one bit high.
- t_data_o  out  BIT_DEPTH  registered output data.
- t_valid_o  out  1  registered output valid.
- t_last_o  out  1  registered output last.
- t_id_o  out  CH_W  index of the channel that sourced the current output beat.
- t_ready_i  in  1  downstream ready.

Behaviour:
- Reset (arstn=0, asynchronous):
  - t_valid_o, t_last_o, t_data_o and t_id_o clear to 0.
  - Round-robin pointer clears to 0; FSM enters IDLE.
  - t_ready_o is all-zero while in reset.
- Transfers:
  - Input beat on channel i is accepted when t_valid_i[i] && t_ready_o[i].
  - Output beat is consumed when t_valid_o && t_ready_i.
- Output register: one entry.
  - can_load = !t_valid_o || t_ready_i.
  - t_ready_o[i] = grant[i] && can_load, so full throughput is one beat per cycle.
- Latency: an accepted beat appears on the outputs on the next rising edge.
  - t_data_o, t_last_o and t_id_o load together; t_valid_o goes to 1.
  - If can_load is true and nothing is accepted, t_valid_o goes to 0.
- Output stability: while t_valid_o=1 and t_ready_i=0, all outputs hold; no beat is dropped or duplicated.
- FSM states:
  - IDLE: grant goes to the first channel with t_valid_i=1, searching ptr, ptr+1, ... mod N_CH. No valid channel means no grant.
  - LOCKED(lock_id): grant goes to lock_id only, regardless of other valids. t_ready_o[lock_id] follows can_load even if t_valid_i[lock_id]=0.
- Transitions, evaluated on an accepted beat from channel g:
  - last=0, from IDLE: go to LOCKED with lock_id=g.
  - last=1: go to IDLE with ptr=(g+1) mod N_CH. Wrap: g=N_CH-1 gives ptr=0.
  - No accepted beat: state and ptr unchanged.
- Single-beat packets (last=1 on the first beat) never enter LOCKED.
- Grant is combinational from state, ptr and t_valid_i. It may change between cycles in IDLE only when nothing was accepted. A source deasserting valid without a handshake is legal in IDLE.
- N_CH=1: arbiter degenerates to a registered pipe with packet tracking; t_id_o is always 0.
- Reset mid-packet: state returns to IDLE and ptr to 0 immediately. The partial packet is abandoned, and its output beat is lost if still held.

Test Plan:
- Reset (N_CH=4, BIT_DEPTH=8): hold arstn=0 with all inputs valid -> t_valid_o=0, t_data_o=0, t_id_o=0, t_ready_o=4'b0000.
- Fairness: ch0..ch3 continuously valid with single-beat packets 0x10..0x13, t_ready_i=1 -> first output one cycle after release; then t_id_o = 0,1,2,3,0,1... and t_data_o = 0x10,0x11,0x12,0x13,0x10..., one beat per cycle.
- Packet lock: ch1 sends 0xA0,0xA1,0xA2 (last on 0xA2); ch2 holds 0xB0, last=1 throughout -> output 0xA0,0xA1,0xA2,0xB0 with t_last_o=1 only on 0xA2 and 0xB0; t_ready_o[2]=0 until 0xA2 is accepted.
- Backpressure: t_ready_i=0 for 3 cycles while t_valid_o=1 with data 0x11 -> t_data_o stays 0x11 and t_ready_o=0; release -> stream resumes with no lost or duplicated beat.
- Wrap: only ch3 valid (0x33, last) -> granted, ptr becomes 0; next ch0 and ch3 both valid -> ch0 output before ch3.
- Reset mid-packet: arstn pulsed low for 3 ns after the second beat of a ch1 packet -> t_valid_o=0 immediately; after release with ch0 and ch1 valid, ch0 is granted first.
